addsub_dispatch: RTL and testbench
==================================

# addsub_dispatch

Upstream issue stage for the single-precision `addsub` unit. It buffers operand pairs in a small FIFO and drives the `addsub` start/done/serv handshake one operation at a time. It captures each result with its overflow flag and presents it on a valid/ready output port, tagged in issue order. `addsub` never sees a new `add_start` before its previous result has been serviced.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `FP_W`, 32: IEEE-754 word width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO not full; request accepted when `req_valid & req_ready`.
- `req_op1`  in  FP_W  first operand.
- `req_op2`  in  FP_W  second operand.
- `req_sub`  in  1  1 = compute op1 − op2.
- `op1`  out  FP_W  to `addsub`.
- `op2`  out  FP_W  to `addsub`.
- `add_start`  out  1  one-cycle start pulse to `addsub`.
- `add_busy`  in  1  `addsub` computing.
- `add_done`  in  1  `add_result`/`add_overflow` valid; held by `addsub` until `add_serv`.
- `add_result`  in  FP_W  sum from `addsub`.
- `add_overflow`  in  1  overflow from `addsub`.
- `add_serv`  out  1  one-cycle acknowledge; releases `add_done`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  FP_W  captured result.
- `res_overflow`  out  1  captured overflow.
- `res_tag`  out  2  issue sequence number, wraps 3→0.

## Operation
- FIFO push stores {op1, op2 with bit FP_W-1 inverted if `req_sub`}. The sign flip is the only arithmetic this block performs.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE→ISSUE when the FIFO is non-empty and `add_busy`=0.
  - ISSUE lasts 1 cycle. It drives `add_start`=1 and `op1`/`op2` from registered copies of the FIFO head, and pops the head at the end of the cycle. ISSUE→WAIT.
  - WAIT→HOLD on `add_done`=1. That edge captures `add_result`, `add_overflow` and the tag counter into the result registers.
  - HOLD: `res_valid`=1. `add_serv`=1 in the first HOLD cycle only. HOLD→IDLE when `res_ready`=1; the tag counter increments on that edge.
- `op1`/`op2` hold their last issued values until the next ISSUE.
- `add_done` in IDLE, ISSUE or HOLD is ignored.
- FIFO full: `req_ready`=0. A push is never accepted in the cycle the FIFO reads full, even when an ISSUE pop occurs in that same cycle.
- FIFO empty: FSM stays in IDLE.
- `rst` in any state, including mid-WAIT:
  - FIFO emptied, FSM to IDLE, tag counter 0.
  - An in-flight `addsub` result is discarded; its `add_done` is ignored after reset.

## Timing
- Reset values: `req_ready`=1, `add_start`=0, `add_serv`=0, `res_valid`=0, `op1`=`op2`=`res_data`=0, `res_overflow`=0, `res_tag`=0.
- Request accepted in cycle 0: entry visible in cycle 1, `add_start` in cycle 2 (earliest).
- `add_done` first seen in cycle k: `res_valid` and `add_serv` both high in cycle k+1.
- Minimum one IDLE cycle between successive issues.
- All outputs are registered or decoded from the FSM state; no combinational path from input to output except `req_ready` from FIFO count.

## Structure
- Package `addsub_pkg`: `FP_W`, `SIGN_BIT`, FSM state enum `dispatch_state_t`, tag width constant.
- Sub-module `op_fifo`: synchronous FIFO (DEPTH × (2·FP_W)) with full/empty flags and a count.

## Test plan
- Single add: 0x40200000 + 0x40600000 (2.5 + 3.5) → `add_start` pulse in cycle 2; `res_data`=0x40C00000, `res_overflow`=0, `res_tag`=0.
- Subtract: 0x40600000 − 0x40200000 with `req_sub`=1 → `op2`=0xC0200000 at `add_start`; `res_data`=0x3F800000.
- Fill: 5 back-to-back requests with `addsub` stalled → first 4 accepted, `req_ready`=0 on the 5th until the first ISSUE pop; results return with tags 0,1,2,3,0.
- Backpressure: hold `res_ready`=0 for 10 cycles in HOLD → `res_valid`, `res_data` and `res_tag` stable; `add_serv` high only in the first HOLD cycle; no new `add_start`.
- Reset mid-WAIT: assert `rst` with 2 queued entries → next cycle all outputs at reset values; late `add_done` produces no `res_valid`.
- Overflow passthrough: `addsub` returns `add_overflow`=1 → `res_overflow`=1 for that tag only.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and types for the addsub issue stage.
package addsub_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = FP_W - 1;
    localparam int unsigned TAG_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand-pair FIFO with full/empty flags and an occupancy count.
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/addsub_dispatch.sv
// Issue stage for the addsub unit: queues operand pairs, runs one start/done/serv
// handshake at a time and presents tagged results on a valid/ready port.
module addsub_dispatch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FP_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [FP_W-1:0] req_op1,
    input  logic [FP_W-1:0] req_op2,
    input  logic            req_sub,
    output logic [FP_W-1:0] op1,
    output logic [FP_W-1:0] op2,
    output logic            add_start,
    input  logic            add_busy,
    input  logic            add_done,
    input  logic [FP_W-1:0] add_result,
    input  logic            add_overflow,
    output logic            add_serv,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_data,
    output logic            res_overflow,
    output logic [1:0]      res_tag
);

    import addsub_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dispatch_state_t   r_state;
    dispatch_state_t   w_next;
    logic [2*FP_W-1:0] w_wdata;
    logic [2*FP_W-1:0] w_head;
    logic [FP_W-1:0]   w_op2_adj;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_go;

    logic [FP_W-1:0]   r_op1;
    logic [FP_W-1:0]   r_op2;
    logic [FP_W-1:0]   r_res_data;
    logic              r_res_ovf;
    logic [TAG_W-1:0]  r_res_tag;
    logic [TAG_W-1:0]  r_tag;
    logic              r_serv;

    // Subtraction is folded into the queued operand as a sign flip.
    assign w_op2_adj = {req_op2[FP_W-1] ^ req_sub, req_op2[FP_W-2:0]};
    assign w_wdata   = {req_op1, w_op2_adj};

    assign req_ready = ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_pop     = (r_state == S_ISSUE) & (w_count != '0);
    assign w_go      = (r_state == S_IDLE) & ~w_empty & ~add_busy;

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (2*FP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (add_done) w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are latched on the IDLE->ISSUE edge so they are stable during the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_res_data <= '0;
            r_res_ovf  <= 1'b0;
            r_res_tag  <= '0;
            r_tag      <= '0;
            r_serv     <= 1'b0;
        end else begin
            r_serv <= 1'b0;
            if (w_go) begin
                r_op1 <= w_head[2*FP_W-1:FP_W];
                r_op2 <= w_head[FP_W-1:0];
            end
            if (r_state == S_WAIT && add_done) begin
                r_res_data <= add_result;
                r_res_ovf  <= add_overflow;
                r_res_tag  <= r_tag;
                r_serv     <= 1'b1;
            end
            if (r_state == S_HOLD && res_ready) begin
                r_tag <= r_tag + TAG_W'(1);
            end
        end
    end

    assign op1          = r_op1;
    assign op2          = r_op2;
    assign add_start    = (r_state == S_ISSUE);
    assign add_serv     = r_serv;
    assign res_valid    = (r_state == S_HOLD);
    assign res_data     = r_res_data;
    assign res_overflow = r_res_ovf;
    assign res_tag      = r_res_tag;

endmodule

// File: tb/tb_addsub_dispatch.sv
// Self-checking bench for addsub_dispatch; the bench plays the addsub unit.
module tb_addsub_dispatch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FP_W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [FP_W-1:0] req_op1;
    logic [FP_W-1:0] req_op2;
    logic            req_sub;
    logic [FP_W-1:0] op1;
    logic [FP_W-1:0] op2;
    logic            add_start;
    logic            add_busy;
    logic            add_done;
    logic [FP_W-1:0] add_result;
    logic            add_overflow;
    logic            add_serv;
    logic            res_valid;
    logic            res_ready;
    logic [FP_W-1:0] res_data;
    logic            res_overflow;
    logic [1:0]      res_tag;

    always #5 clk = ~clk;

    addsub_dispatch #(
        .DEPTH (DEPTH),
        .FP_W  (FP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_sub      (req_sub),
        .op1          (op1),
        .op2          (op2),
        .add_start    (add_start),
        .add_busy     (add_busy),
        .add_done     (add_done),
        .add_result   (add_result),
        .add_overflow (add_overflow),
        .add_serv     (add_serv),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_tag      (res_tag)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: operand pairs in acceptance order, and results delivered since reset.
    logic [63:0] exp_q[$];
    int          n_results = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_add_start"}, 32'(add_start), 32'd0);
        chk({pfx, "_add_serv"}, 32'(add_serv), 32'd0);
        chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({pfx, "_op1"}, op1, 32'd0);
        chk({pfx, "_op2"}, op2, 32'd0);
        chk({pfx, "_res_data"}, res_data, 32'd0);
        chk({pfx, "_res_overflow"}, 32'(res_overflow), 32'd0);
        chk({pfx, "_res_tag"}, 32'(res_tag), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_results = 0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic s);
        int unsigned guard = 0;
        req_valid = 1'b1;
        req_op1   = a;
        req_op2   = b;
        req_sub   = s;
        while (req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk("push_accept", 32'(req_ready), 32'd1);
        if (req_ready === 1'b1) exp_q.push_back({a, s ? (b ^ 32'h8000_0000) : b});
        tick();
        req_valid = 1'b0;
    endtask

    // Returns in the ISSUE cycle with addsub marked busy.
    task automatic wait_issue();
        int unsigned guard = 0;
        logic [63:0] e;
        while (add_start !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        chk("add_start_seen", 32'(add_start), 32'd1);
        e = 64'hx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("issue_op1", op1, e[63:32]);
        chk("issue_op2", op2, e[31:0]);
        add_busy = 1'b1;
    endtask

    // Called in a WAIT cycle; completes the handshake and drains the result.
    task automatic finish_op(input logic [31:0] result, input logic ovf,
                             input int unsigned lat, input int unsigned hold);
        logic [31:0] exp_tag;
        exp_tag = 32'(n_results % 4);
        chk("wait_no_start", 32'(add_start), 32'd0);
        chk("wait_no_valid", 32'(res_valid), 32'd0);
        for (int unsigned i = 0; i < lat; i++) begin
            tick();
            chk("wait_no_valid", 32'(res_valid), 32'd0);
        end
        add_done     = 1'b1;
        add_result   = result;
        add_overflow = ovf;
        tick();
        chk("hold_res_valid", 32'(res_valid), 32'd1);
        chk("hold_add_serv", 32'(add_serv), 32'd1);
        chk("hold_res_data", res_data, result);
        chk("hold_res_overflow", 32'(res_overflow), 32'(ovf));
        chk("hold_res_tag", 32'(res_tag), exp_tag);
        add_done     = 1'b0;
        add_busy     = 1'b0;
        add_result   = $urandom;
        add_overflow = ~ovf;
        for (int unsigned i = 0; i < hold; i++) begin
            tick();
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_add_serv", 32'(add_serv), 32'd0);
            chk("bp_add_start", 32'(add_start), 32'd0);
            chk("bp_res_data", res_data, result);
            chk("bp_res_tag", 32'(res_tag), exp_tag);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("drain_res_valid", 32'(res_valid), 32'd0);
        chk("idle_gap_start", 32'(add_start), 32'd0);
        n_results++;
    endtask

    task automatic do_op(input logic [31:0] result, input logic ovf,
                         input int unsigned lat, input int unsigned hold);
        wait_issue();
        tick();
        finish_op(result, ovf, lat, hold);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op1      = '0;
        req_op2      = '0;
        req_sub      = 1'b0;
        add_busy     = 1'b0;
        add_done     = 1'b0;
        add_result   = '0;
        add_overflow = 1'b0;
        res_ready    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("rst_init");

        // Single add with earliest-start timing.
        push_req(32'h4020_0000, 32'h4060_0000, 1'b0);
        chk("t1_cycle1_start", 32'(add_start), 32'd0);
        tick();
        chk("t1_cycle2_start", 32'(add_start), 32'd1);
        wait_issue();
        tick();
        finish_op(32'h40C0_0000, 1'b0, 1, 0);

        // Subtract: op2 sign flipped at issue.
        push_req(32'h4060_0000, 32'h4020_0000, 1'b1);
        wait_issue();
        chk("sub_op2_const", op2, 32'hC020_0000);
        tick();
        finish_op(32'h3F80_0000, 1'b0, 2, 0);

        // Overflow passthrough.
        push_req(32'h7F00_0000, 32'h7F00_0000, 1'b0);
        do_op(32'h7F80_0000, 1'b1, 0, 0);

        // Backpressure in HOLD for 10 cycles.
        push_req($urandom, $urandom, 1'b0);
        do_op($urandom, 1'b0, 1, 10);

        // Fill with addsub stalled, then drain with tags 0,1,2,3,0.
        do_reset();
        add_busy = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_op1   = $urandom;
            req_op2   = $urandom;
            req_sub   = 1'(i & 1);
            chk("fill_ready", 32'(req_ready), 32'd1);
            exp_q.push_back({req_op1, req_sub ? (req_op2 ^ 32'h8000_0000) : req_op2});
            tick();
        end
        req_op1 = 32'h1234_5678;
        req_op2 = 32'h8765_4321;
        req_sub = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            chk("full_ready", 32'(req_ready), 32'd0);
            tick();
        end
        add_busy = 1'b0;
        chk("full_ready", 32'(req_ready), 32'd0);
        tick();
        chk("full_issue_ready", 32'(req_ready), 32'd0);
        chk("full_issue_start", 32'(add_start), 32'd1);
        wait_issue();
        tick();
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        exp_q.push_back({32'h1234_5678, 32'h0765_4321});
        tick();
        req_valid = 1'b0;
        finish_op($urandom, 1'b0, 0, 0);
        for (int unsigned i = 0; i < 4; i++) do_op($urandom, 1'b0, 1, 0);

        // Reset mid-WAIT with two entries queued; late add_done must be ignored.
        push_req(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        push_req(32'h4000_0000, 32'h4000_0000, 1'b0);
        push_req(32'h4040_0000, 32'h4040_0000, 1'b0);
        add_busy = 1'b1;
        chk("midwait_no_valid", 32'(res_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_results = 0;
        check_reset("rst_wait");
        add_done   = 1'b1;
        add_result = 32'hDEAD_BEEF;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("late_done_valid", 32'(res_valid), 32'd0);
            chk("late_done_serv", 32'(add_serv), 32'd0);
            chk("late_done_start", 32'(add_start), 32'd0);
        end
        add_done = 1'b0;
        add_busy = 1'b0;
        repeat (2) begin
            tick();
            chk("post_rst_empty", 32'(add_start), 32'd0);
        end

        // Randomized batches against the model.
        for (int unsigned b = 0; b < 8; b++) begin
            k = $urandom_range(1, 4);
            add_busy = 1'b1;
            for (int unsigned i = 0; i < k; i++) push_req($urandom, $urandom, 1'($urandom_range(0, 1)));
            add_busy = 1'b0;
            for (int unsigned i = 0; i < k; i++)
                do_op($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
